// File: rtl/match_ctrl_if.sv
// Physics-engine link: result strobe/flags toward the controller, update enable back.
interface match_ctrl_if;
    logic       phys_valid;
    logic       phys_game_over;
    logic [1:0] phys_winner;
    logic       phys_en;

    // Controller side: consumes physics results, issues the update enable.
    modport master (
        input  phys_valid,
        input  phys_game_over,
        input  phys_winner,
        output phys_en
    );

    // Physics-engine side.
    modport slave (
        output phys_valid,
        output phys_game_over,
        output phys_winner,
        input  phys_en
    );
endinterface

// File: rtl/match_ctrl.sv
// Match controller: frame timing, serve/point delays, scoring, pause and match end.
module match_ctrl #(
    parameter int unsigned CLK_PER_FRAME = 1666667,
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned POINT_FRAMES  = 90,
    parameter int unsigned WIN_SCORE     = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_btn,
    input  logic                pause_btn,
    match_ctrl_if.master        phys,
    output logic                frame_tick,
    output logic [4:0]          score_p1,
    output logic [4:0]          score_p2,
    output logic [1:0]          match_winner,
    output logic [2:0]          state
);

    localparam int unsigned FRM_W   = (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
    localparam int unsigned DLY_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam int unsigned SCORE_W = 5;

    localparam logic [FRM_W-1:0]   FRM_LAST  = FRM_W'(CLK_PER_FRAME - 1);
    localparam logic [DLY_W-1:0]   DLY_SERVE = DLY_W'(SERVE_FRAMES);
    localparam logic [DLY_W-1:0]   DLY_POINT = DLY_W'(POINT_FRAMES);
    localparam logic [DLY_W-1:0]   DLY_ONE   = DLY_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FRM_W-1:0]     r_frame_cnt;
    logic                 r_frame_tick;
    logic                 r_start_q;
    logic                 r_pause_q;
    logic [DLY_W-1:0]     r_dly;
    logic [DLY_W-1:0]     w_dly_nxt;
    logic [SCORE_W-1:0]   r_score_p1;
    logic [SCORE_W-1:0]   r_score_p2;
    logic [SCORE_W-1:0]   w_score_p1_nxt;
    logic [SCORE_W-1:0]   w_score_p2_nxt;
    logic [1:0]           r_winner;
    logic [1:0]           w_winner_nxt;
    logic                 r_phys_en;
    logic                 w_phys_en_nxt;

    logic                 w_start_edge;
    logic                 w_pause_edge;
    logic                 w_score_evt;
    logic                 w_p1_point;
    logic [SCORE_W-1:0]   w_p1_inc;
    logic [SCORE_W-1:0]   w_p2_inc;
    logic                 w_win_hit;
    logic                 w_dly_done;

    assign w_start_edge = start_btn & ~r_start_q;
    assign w_pause_edge = pause_btn & ~r_pause_q;
    assign w_score_evt  = phys.phys_valid & phys.phys_game_over &
                          ((phys.phys_winner == 2'd1) | (phys.phys_winner == 2'd2));
    assign w_p1_point   = (phys.phys_winner == 2'd1);
    assign w_p1_inc     = r_score_p1 + SCORE_W'(1);
    assign w_p2_inc     = r_score_p2 + SCORE_W'(1);
    assign w_win_hit    = w_p1_point ? (w_p1_inc == WIN_VAL) : (w_p2_inc == WIN_VAL);
    assign w_dly_done   = r_frame_tick & (r_dly == DLY_ONE);

    // Free-running frame counter and registered wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_cnt  <= (r_frame_cnt == FRM_LAST) ? '0 : r_frame_cnt + FRM_W'(1);
            r_frame_tick <= (r_frame_cnt == FRM_LAST);
        end
    end

    // Prior-level copies of the buttons for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_pause_q <= 1'b0;
        end else begin
            r_start_q <= start_btn;
            r_pause_q <= pause_btn;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a scoring strobe wins over a same-cycle pause edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_edge) w_state_nxt = ST_SERVE;
            ST_SERVE: if (w_dly_done)   w_state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (w_score_evt)       w_state_nxt = w_win_hit ? ST_OVER : ST_POINT;
                else if (w_pause_edge) w_state_nxt = ST_PAUSE;
            end
            ST_POINT: if (w_dly_done)   w_state_nxt = ST_SERVE;
            ST_OVER:  if (w_start_edge) w_state_nxt = ST_SERVE;
            ST_PAUSE: if (w_pause_edge) w_state_nxt = ST_PLAY;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for delay counter, scores, winner and physics enable.
    always_comb begin
        w_dly_nxt      = r_dly;
        w_score_p1_nxt = r_score_p1;
        w_score_p2_nxt = r_score_p2;
        w_winner_nxt   = r_winner;
        // Enable only for a tick seen in PLAY that also stays in PLAY.
        w_phys_en_nxt  = r_frame_tick & (r_state == ST_PLAY) & (w_state_nxt == ST_PLAY);
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_dly_nxt = DLY_SERVE;
            end
            ST_SERVE: begin
                if (r_frame_tick && !w_dly_done) w_dly_nxt = r_dly - DLY_ONE;
            end
            ST_PLAY: begin
                if (w_score_evt) begin
                    if (w_p1_point) begin
                        if (r_score_p1 < WIN_VAL) w_score_p1_nxt = w_p1_inc;
                    end else begin
                        if (r_score_p2 < WIN_VAL) w_score_p2_nxt = w_p2_inc;
                    end
                    if (w_win_hit) w_winner_nxt = phys.phys_winner;
                    else           w_dly_nxt    = DLY_POINT;
                end
            end
            ST_POINT: begin
                if (w_dly_done)        w_dly_nxt = DLY_SERVE;
                else if (r_frame_tick) w_dly_nxt = r_dly - DLY_ONE;
            end
            ST_OVER: begin
                if (w_start_edge) begin
                    w_score_p1_nxt = '0;
                    w_score_p2_nxt = '0;
                    w_winner_nxt   = 2'd0;
                    w_dly_nxt      = DLY_SERVE;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly      <= '0;
            r_score_p1 <= '0;
            r_score_p2 <= '0;
            r_winner   <= 2'd0;
            r_phys_en  <= 1'b0;
        end else begin
            r_dly      <= w_dly_nxt;
            r_score_p1 <= w_score_p1_nxt;
            r_score_p2 <= w_score_p2_nxt;
            r_winner   <= w_winner_nxt;
            r_phys_en  <= w_phys_en_nxt;
        end
    end

    assign phys.phys_en = r_phys_en;
    assign frame_tick   = r_frame_tick;
    assign score_p1     = r_score_p1;
    assign score_p2     = r_score_p2;
    assign match_winner = r_winner;
    assign state        = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl with a frame/rule-level reference model.
module tb_match_ctrl;

    localparam int CPF = 4;
    localparam int SF  = 2;
    localparam int PF  = 3;
    localparam int WS  = 3;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       pause_btn;
    logic       phys_valid;
    logic       phys_game_over;
    logic [1:0] phys_winner;
    logic       frame_tick;
    logic [4:0] score_p1;
    logic [4:0] score_p2;
    logic [1:0] match_winner;
    logic [2:0] state;

    match_ctrl_if u_if ();
    assign u_if.phys_valid     = phys_valid;
    assign u_if.phys_game_over = phys_game_over;
    assign u_if.phys_winner    = phys_winner;

    match_ctrl #(
        .CLK_PER_FRAME (CPF),
        .SERVE_FRAMES  (SF),
        .POINT_FRAMES  (PF),
        .WIN_SCORE     (WS)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .phys         (u_if),
        .frame_tick   (frame_tick),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .match_winner (match_winner),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [1:0] win;
        logic       en;
        logic       tick;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: match phase, frames left in a timed phase, scores, edge count.
    int m_mode, m_left, m_s1, m_s2, m_win, m_n;
    bit m_tick, m_en, m_ps, m_pp;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_n = 0;
        m_tick = 0; m_en = 0; m_ps = 0; m_pp = 0;
    endtask

    // Apply the inputs sampled at the clock edge that just happened.
    task automatic model_step();
        int   old;
        bit   t, se, pe;
        obs_t e;
        m_n++;
        t  = m_tick;
        se = start_btn && !m_ps;
        pe = pause_btn && !m_pp;
        m_ps = start_btn;
        m_pp = pause_btn;
        old = m_mode;
        case (m_mode)
            0: if (se) begin m_mode = 1; m_left = SF; end
            1: if (t) begin
                   if (m_left == 1) m_mode = 2; else m_left--;
               end
            2: if (phys_valid && phys_game_over && (phys_winner == 2'd1 || phys_winner == 2'd2)) begin
                   if (phys_winner == 2'd1) m_s1++; else m_s2++;
                   if (m_s1 == WS || m_s2 == WS) begin m_mode = 4; m_win = int'(phys_winner); end
                   else begin m_mode = 3; m_left = PF; end
               end else if (pe) m_mode = 5;
            3: if (t) begin
                   if (m_left == 1) begin m_mode = 1; m_left = SF; end else m_left--;
               end
            4: if (se) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_mode = 1; m_left = SF; end
            5: if (pe) m_mode = 2;
            default: m_mode = 0;
        endcase
        m_en   = t && (old == 2) && (m_mode == 2);
        m_tick = ((m_n % CPF) == 0);
        e.st   = 3'(m_mode);
        e.s1   = 5'(m_s1);
        e.s2   = 5'(m_s2);
        e.win  = 2'(m_win);
        e.en   = m_en;
        e.tick = m_tick;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation each cycle.
    initial begin
        obs_t got, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state, score_p1, score_p2, match_winner, u_if.phys_en, frame_tick};
                n_checks++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL obs t=%0t got st=%0d s1=%0d s2=%0d win=%0d en=%0b tick=%0b need st=%0d s1=%0d s2=%0d win=%0d en=%0b tick=%0b",
                             $time, got.st, got.s1, got.s2, got.win, got.en, got.tick,
                             e.st, e.s1, e.s2, e.win, e.en, e.tick);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d need=%0d", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},  int'(state), 0);
        chk({tag, "_en"},     int'(u_if.phys_en), 0);
        chk({tag, "_tick"},   int'(frame_tick), 0);
        chk({tag, "_s1"},     int'(score_p1), 0);
        chk({tag, "_s2"},     int'(score_p2), 0);
        chk({tag, "_winner"}, int'(match_winner), 0);
    endtask

    // One clock: hold the given inputs across the next rising edge.
    task automatic cyc(input bit s, input bit p, input bit v, input bit g, input logic [1:0] w);
        start_btn      = s;
        pause_btn      = p;
        phys_valid     = v;
        phys_game_over = g;
        phys_winner    = w;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wait_play(input int budget);
        int k = 0;
        while (m_mode != 2 && k < budget) begin
            cyc(0, 0, 0, 0, 2'd0);
            k++;
        end
        if (m_mode != 2) begin
            n_err++;
            $display("FAIL wait_play budget=%0d expired", budget);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        start_btn = 0; pause_btn = 0; phys_valid = 0; phys_game_over = 0; phys_winner = 2'd0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        start_btn = 0; pause_btn = 0; phys_valid = 0; phys_game_over = 0; phys_winner = 2'd0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("por");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Start held for several cycles gives a single edge; serve then play.
        repeat (3) cyc(0, 0, 0, 0, 2'd0);
        repeat (3) cyc(1, 0, 0, 0, 2'd0);
        wait_play(40);
        repeat (12) cyc(0, 0, 0, 0, 2'd0);

        // Non-scoring strobes in play.
        cyc(0, 0, 1, 1, 2'd0);
        cyc(0, 0, 1, 1, 2'd3);
        cyc(0, 0, 1, 0, 2'd1);
        repeat (2) cyc(0, 0, 0, 0, 2'd0);

        // P2 point, late strobes during the point pause.
        cyc(0, 0, 1, 1, 2'd2);
        repeat (2) cyc(0, 0, 1, 1, 2'd1);
        wait_play(60);
        repeat (6) cyc(0, 0, 0, 0, 2'd0);

        // Pause for more than 10 frames with start held; strobe inside pause.
        cyc(1, 1, 0, 0, 2'd0);
        for (int i = 0; i < 44; i++) cyc(1, 1, i == 20, i == 20, 2'd1);
        cyc(1, 0, 0, 0, 2'd0);
        cyc(1, 1, 0, 0, 2'd0);
        repeat (8) cyc(0, 0, 0, 0, 2'd0);

        // Pause edge together with a scoring strobe.
        wait_play(60);
        cyc(0, 1, 1, 1, 2'd1);
        cyc(0, 0, 0, 0, 2'd0);

        // P1 runs out the match.
        wait_play(60);
        cyc(0, 0, 1, 1, 2'd1);
        wait_play(60);
        cyc(0, 0, 1, 1, 2'd1);
        for (int i = 0; i < 10; i++) cyc(0, (i % 2) == 1, 1, 1, 2'd2);
        cyc(1, 0, 0, 0, 2'd0);
        repeat (6) cyc(0, 0, 0, 0, 2'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                2'($urandom_range(0, 3)));

        // Reach 2:1 in play, then reset mid-rally.
        do_reset("clr");
        cyc(1, 0, 0, 0, 2'd0);
        wait_play(40);
        cyc(0, 0, 1, 1, 2'd1);
        wait_play(60);
        cyc(0, 0, 1, 1, 2'd2);
        wait_play(60);
        cyc(0, 0, 1, 1, 2'd1);
        wait_play(60);
        repeat (3) cyc(0, 0, 0, 0, 2'd0);
        chk("pre_rst_s1", int'(score_p1), 2);
        chk("pre_rst_s2", int'(score_p2), 1);
        do_reset("mid");

        // Normal operation resumes after release.
        repeat (2) cyc(0, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 0, 2'd0);
        wait_play(40);
        repeat (10) cyc(0, 0, 0, 0, 2'd0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_FRAME, default 1666667, clock cycles per game frame (>=2).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames of pre-serve hold (>=1).
REQ-003 SHALL have parameter POINT_FRAMES, default 90, frames of post-point pause (>=1).
REQ-004 SHALL have parameter WIN_SCORE, default 15, points needed to win the match (1..31).
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port start_btn  input  1  start/restart request, level, already synchronous to clk.
REQ-008 SHALL have port pause_btn  input  1  pause toggle request, level, already synchronous to clk.
REQ-009 SHALL have port phys_valid  input  1  physics engine result-valid strobe.
REQ-010 SHALL have port phys_game_over  input  1  physics engine "ball landed" flag.
REQ-011 SHALL have port phys_winner  input  2  physics engine point winner: 1 = P1, 2 = P2, 0/3 = none.
REQ-012 SHALL have port phys_en  output  1  physics engine update enable, one-cycle pulse.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse per frame, for render sync.
REQ-014 SHALL have port score_p1, score_p2  output  5 each  current scores.
REQ-015 SHALL have port match_winner  output  2  0 = none, 1 = P1, 2 = P2.
REQ-016 SHALL have port state  output  3  state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5.

Function
REQ-017 SHALL run a free-running frame counter 0..CLK_PER_FRAME-1 in every state; frame_tick is registered and high for one cycle when the counter wraps.
REQ-018 SHALL detect start and pause as rising edges against a registered copy of the prior level; a held level produces one edge only.
REQ-019 SHALL assert phys_en for exactly one cycle, the cycle after frame_tick, only while state is PLAY; phys_en is never high in any other state.
REQ-020 SHALL, in IDLE: on a start edge, go to SERVE and load the delay counter with SERVE_FRAMES.
REQ-021 SHALL, in SERVE and POINT: on each frame_tick, leave the state if the delay counter equals 1, else decrement it; the state therefore lasts exactly N frame ticks.
REQ-022 SHALL, in SERVE: exit to PLAY.
REQ-023 SHALL, in POINT: exit to SERVE and reload the delay counter with SERVE_FRAMES.
REQ-024 SHALL, in PLAY, on phys_valid=1 and phys_game_over=1 with phys_winner 1 or 2, increment that player's score.
REQ-025 SHALL, after a REQ-024 increment: go to OVER and set match_winner to that player if the new score equals WIN_SCORE; otherwise go to POINT and load POINT_FRAMES.
REQ-026 SHALL, in PLAY, ignore game_over when phys_winner is 0 or 3 (no score change, stay in PLAY); phys_valid without game_over is ignored.
REQ-027 SHALL, in PLAY: a pause edge goes to PAUSE; in PAUSE, a pause edge returns to PLAY.
REQ-028 SHALL freeze the delay counter, scores and phys_en (0) while in PAUSE; the frame counter keeps running.
REQ-029 SHALL ignore pause edges outside PLAY and PAUSE.
REQ-030 SHALL ignore start edges except in IDLE and OVER.
REQ-031 SHALL, in OVER: on a start edge, clear both scores and match_winner, go to SERVE and load SERVE_FRAMES.
REQ-032 SHALL give a scoring event priority over a pause edge arriving in the same cycle; the pause edge is discarded.
REQ-033 SHALL ignore phys_valid in every state except PLAY, including a late strobe arriving in POINT or PAUSE.
REQ-034 SHALL never let scores exceed WIN_SCORE and never let them wrap.

Reset
REQ-035 SHALL, on rst_n low at any time (including mid-match), immediately set: state=IDLE, phys_en=0, frame_tick=0, score_p1=0, score_p2=0, match_winner=0, frame counter=0, delay counter=0, button edge registers=0.
REQ-036 SHALL resume normal operation on the first rising clk edge after rst_n goes high.

Verification (parameters CLK_PER_FRAME=4, SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3)
REQ-037 SHALL cover: start edge in IDLE -> SERVE for exactly 2 frame_ticks, then PLAY, with the first phys_en one cycle after the next frame_tick; phys_en then has a period of 4 cycles.
REQ-038 SHALL cover: in PLAY, phys_valid+game_over with winner=2 -> score_p2=1, POINT for 3 ticks, SERVE for 2 ticks, back to PLAY; winner=0 -> no change.
REQ-039 SHALL cover: three P1 points -> score_p1=3, match_winner=1, state=OVER, phys_en stays 0; start edge -> scores=0, match_winner=0, state=SERVE.
REQ-040 SHALL cover: pause edge in PLAY -> PAUSE with no phys_en for 10 frames; second edge -> PLAY; start_btn held high across this produces no effect.
REQ-041 SHALL cover: pause edge coinciding with a scoring strobe -> score increments and state=POINT, not PAUSE.
REQ-042 SHALL cover: rst_n asserted mid-PLAY with score 2:1 -> all outputs return to their reset values asynchronously, with no clock edge required.
